// File: rtl/turnstile_if.sv
// turnstile_if: groups the turnstile front-end inputs and the gate/status
// outputs into one bundle.
//
// Signals:
//   coin        front end -> controller, one coin per cycle while high
//   push        front end -> controller, arm pushed this cycle
//   locked      controller -> gate, gate locked
//   alarm       controller -> status, forced-entry alarm
//   credit      controller -> status, stored credit (CW bits)
//   passed      controller -> status, 1-cycle pulse per paid passage
//   timeout_evt controller -> status, 1-cycle pulse when the unlock expires
//   coin_reject controller -> status, 1-cycle pulse for a coin refused at full credit
//
// Transfer rule: coin and push are single-cycle qualifiers with no ready/
// backpressure; every cycle they are high counts as one event, sampled on
// the rising clock edge. All outputs change only on that edge.

interface turnstile_if #(
    parameter int CW = 3
);
    logic          coin;
    logic          push;
    logic          locked;
    logic          alarm;
    logic [CW-1:0] credit;
    logic          passed;
    logic          timeout_evt;
    logic          coin_reject;

    modport master (
        output coin, push,
        input  locked, alarm, credit, passed, timeout_evt, coin_reject
    );

    modport slave (
        input  coin, push,
        output locked, alarm, credit, passed, timeout_evt, coin_reject
    );
endinterface

// File: rtl/turnstile_fare_controller.sv
// turnstile_fare_controller: coin-credit turnstile with a per-passage fare,
// saturating credit, unlock timeout and timed forced-entry alarm.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        turnstile_if.slave: coin/push in; locked, alarm, credit,
//              passed, timeout_evt, coin_reject out (all registered)
//   state_dbg  current FSM state encoding (0 LOCKED, 1 UNLOCKED, 2 ALARM)
//
// The bus interface must be instantiated with CW = $clog2(MAX_CREDIT+1).

module turnstile_fare_controller #(
    parameter int FARE       = 2,
    parameter int MAX_CREDIT = 7,
    parameter int TIMEOUT    = 16,
    parameter int ALARM_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    turnstile_if.slave  bus,
    output logic [1:0]  state_dbg
);
    localparam int CW = $clog2(MAX_CREDIT + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HW = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;

    // Credit arithmetic is done one bit wider so +coin never wraps.
    localparam logic [CW:0]   FARE_W    = (CW + 1)'(FARE);
    localparam logic [CW:0]   MAX_W     = (CW + 1)'(MAX_CREDIT);
    localparam logic [CW:0]   ONE_W     = (CW + 1)'(1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(ALARM_HOLD - 1);

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_UNLOCKED = 2'd1,
        S_ALARM    = 2'd2
    } state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic [HW-1:0]  hold;

    logic           deduct;
    logic           reject_next;
    logic [CW:0]    credit_ext;
    logic [CW:0]    credit_sum;

    assign state_dbg = state;

    // Fare is taken only on the LOCKED->UNLOCKED edge; a coin arriving in
    // that same cycle is still accepted and never rejected.
    always_comb begin
        credit_ext  = {1'b0, bus.credit};
        deduct      = (state == S_LOCKED) && (credit_ext >= FARE_W);
        reject_next = 1'b0;
        credit_sum  = credit_ext;
        if (deduct) begin
            credit_sum = credit_ext - FARE_W + {{CW{1'b0}}, bus.coin};
        end else if (bus.coin) begin
            if (credit_ext == MAX_W) begin
                reject_next = 1'b1;
            end else begin
                credit_sum = credit_ext + ONE_W;
            end
        end
        if (credit_sum > MAX_W) begin
            credit_sum = MAX_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_LOCKED;
            timer           <= '0;
            hold            <= '0;
            bus.credit      <= '0;
            bus.locked      <= 1'b1;
            bus.alarm       <= 1'b0;
            bus.passed      <= 1'b0;
            bus.timeout_evt <= 1'b0;
            bus.coin_reject <= 1'b0;
        end else begin
            bus.credit      <= credit_sum[CW-1:0];
            bus.coin_reject <= reject_next;
            bus.passed      <= 1'b0;
            bus.timeout_evt <= 1'b0;
            case (state)
                S_LOCKED: begin
                    // Paid credit wins over a simultaneous push.
                    if (deduct) begin
                        state      <= S_UNLOCKED;
                        timer      <= '0;
                        bus.locked <= 1'b0;
                        bus.alarm  <= 1'b0;
                    end else if (bus.push) begin
                        state      <= S_ALARM;
                        hold       <= HOLD_LOAD;
                        bus.locked <= 1'b1;
                        bus.alarm  <= 1'b1;
                    end else begin
                        bus.locked <= 1'b1;
                        bus.alarm  <= 1'b0;
                    end
                end
                S_UNLOCKED: begin
                    if (bus.push) begin
                        state      <= S_LOCKED;
                        bus.passed <= 1'b1;
                        bus.locked <= 1'b1;
                    end else if (timer == TMO_LAST) begin
                        state           <= S_LOCKED;
                        bus.timeout_evt <= 1'b1;
                        bus.locked      <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_ALARM: begin
                    // hold counts remaining alarm cycles minus one; a push
                    // restarts the full hold period.
                    if (bus.push) begin
                        hold <= HOLD_LOAD;
                    end else if (hold == '0) begin
                        state     <= S_LOCKED;
                        bus.alarm <= 1'b0;
                    end else begin
                        hold <= hold - 1'b1;
                    end
                end
                default: begin
                    state      <= S_LOCKED;
                    timer      <= '0;
                    hold       <= '0;
                    bus.locked <= 1'b1;
                    bus.alarm  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_turnstile_fare_controller.sv
// tb_turnstile_fare_controller: drives two controller instances (default
// parameters, and FARE=8/MAX_CREDIT=8/TIMEOUT=3/ALARM_HOLD=1) with directed
// and random coin/push/reset traffic, and compares every cycle against a
// behavioural model that tracks mode plus "cycles remaining" counts.

module tb_turnstile_fare_controller;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turnstile_if #(.CW(3)) bus_a ();
    turnstile_if #(.CW(4)) bus_b ();
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    turnstile_fare_controller #(
        .FARE(2), .MAX_CREDIT(7), .TIMEOUT(16), .ALARM_HOLD(8)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(dbg_a)
    );

    turnstile_fare_controller #(
        .FARE(8), .MAX_CREDIT(8), .TIMEOUT(3), .ALARM_HOLD(1)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(dbg_b)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 locked, 1 unlocked, 2 alarm. unl_left / alm_left are the
    // number of cycles still to be spent in that mode, including this one.
    typedef struct packed {
        int   mode;
        int   credit;
        int   unl_left;
        int   alm_left;
        logic passed;
        logic tevt;
        logic rej;
    } mdl_t;

    function automatic mdl_t step(mdl_t m, logic r, logic c, logic p,
                                  int fare, int maxc, int tmo, int hold);
        mdl_t n;
        logic ded;
        n = m;
        if (r) begin
            n = '0;
            return n;
        end
        n.passed = 1'b0;
        n.tevt   = 1'b0;
        n.rej    = 1'b0;
        ded      = 1'b0;
        if (m.mode == 0) begin
            if (m.credit >= fare) begin
                n.mode = 1; n.unl_left = tmo; ded = 1'b1;
            end else if (p) begin
                n.mode = 2; n.alm_left = hold;
            end
        end else if (m.mode == 1) begin
            if (p) begin
                n.mode = 0; n.passed = 1'b1;
            end else if (m.unl_left == 1) begin
                n.mode = 0; n.tevt = 1'b1;
            end else begin
                n.unl_left = m.unl_left - 1;
            end
        end else begin
            if (p) n.alm_left = hold;
            else if (m.alm_left == 1) n.mode = 0;
            else n.alm_left = m.alm_left - 1;
        end
        if (ded) begin
            n.credit = m.credit - fare + int'(c);
            if (n.credit > maxc) n.credit = maxc;
        end else if (c) begin
            if (m.credit == maxc) n.rej = 1'b1;
            else n.credit = m.credit + 1;
        end
        return n;
    endfunction

    mdl_t ma;
    mdl_t mb;
    always @(posedge clk) begin
        ma <= step(ma, rst, bus_a.coin, bus_a.push, 2, 7, 16, 8);
        mb <= step(mb, rst, bus_b.coin, bus_b.push, 8, 8, 3, 1);
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.locked", int'(bus_a.locked), int'(ma.mode != 1));
            chk("a.alarm", int'(bus_a.alarm), int'(ma.mode == 2));
            chk("a.credit", int'(bus_a.credit), ma.credit);
            chk("a.passed", int'(bus_a.passed), int'(ma.passed));
            chk("a.timeout_evt", int'(bus_a.timeout_evt), int'(ma.tevt));
            chk("a.coin_reject", int'(bus_a.coin_reject), int'(ma.rej));
            chk("b.locked", int'(bus_b.locked), int'(mb.mode != 1));
            chk("b.alarm", int'(bus_b.alarm), int'(mb.mode == 2));
            chk("b.credit", int'(bus_b.credit), mb.credit);
            chk("b.passed", int'(bus_b.passed), int'(mb.passed));
            chk("b.timeout_evt", int'(bus_b.timeout_evt), int'(mb.tevt));
            chk("b.coin_reject", int'(bus_b.coin_reject), int'(mb.rej));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic c, input logic p);
        bus_a.coin = c;
        bus_a.push = p;
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".locked"}, int'(bus_a.locked), 1);
        chk({tag, ".alarm"}, int'(bus_a.alarm), 0);
        chk({tag, ".credit"}, int'(bus_a.credit), 0);
        chk({tag, ".pulses"},
            int'({bus_a.passed, bus_a.timeout_evt, bus_a.coin_reject}), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bus_a.coin = 1'b0; bus_a.push = 1'b0;
        bus_b.coin = 1'b0; bus_b.push = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Two coins, unlock, passage.
        drive_a(1, 0);
        chk("t1.credit1", int'(bus_a.credit), 1);
        drive_a(1, 0);
        chk("t1.credit2", int'(bus_a.credit), 2);
        chk("t1.still_locked", int'(bus_a.locked), 1);
        drive_a(0, 0);
        chk("t1.unlocked", int'(bus_a.locked), 0);
        chk("t1.credit_after_fare", int'(bus_a.credit), 0);
        drive_a(0, 1);
        chk("t1.relock", int'(bus_a.locked), 1);
        chk("t1.passed", int'(bus_a.passed), 1);
        drive_a(0, 0);
        chk("t1.passed_one_cycle", int'(bus_a.passed), 0);

        // Forced entry with credit 1; push at hold cycle 5 restarts the hold.
        drive_a(1, 0);
        drive_a(0, 1);
        chk("t2.alarm", int'(bus_a.alarm), 1);
        chk("t2.alarm_locked", int'(bus_a.locked), 1);
        drive_a(0, 0); drive_a(0, 0); drive_a(0, 0); drive_a(0, 0);
        drive_a(0, 1);
        bus_a.push = 1'b0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_a.alarm) n++;
            else break;
        end
        chk("t2.alarm_cycles", n, 8);
        chk("t2.credit_kept", int'(bus_a.credit), 1);

        // Unlock then no push: exactly 16 unlocked cycles, then timeout.
        drive_a(1, 0);
        drive_a(0, 0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus_a.locked) n++;
            else break;
        end
        chk("t3.unlock_cycles", n, 16);
        chk("t3.timeout_evt", int'(bus_a.timeout_evt), 1);
        chk("t3.no_passed", int'(bus_a.passed), 0);

        // Second run: push on unlocked cycle 16 is a passage.
        drive_a(1, 0);
        drive_a(1, 0);
        drive_a(0, 0);
        for (int i = 0; i < 15; i++) drive_a(0, 0);
        chk("t3b.still_unlocked", int'(bus_a.locked), 0);
        drive_a(0, 1);
        chk("t3b.passed", int'(bus_a.passed), 1);
        chk("t3b.no_timeout", int'(bus_a.timeout_evt), 0);
        bus_a.push = 1'b0;

        // Saturation while held in alarm.
        drive_a(0, 1);
        for (int i = 0; i < 7; i++) drive_a(1, 1);
        chk("t4.credit_sat", int'(bus_a.credit), 7);
        chk("t4.no_reject_yet", int'(bus_a.coin_reject), 0);
        drive_a(1, 1);
        chk("t4.reject", int'(bus_a.coin_reject), 1);
        chk("t4.credit_held", int'(bus_a.credit), 7);
        bus_a.coin = 1'b0; bus_a.push = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus_a.alarm) break;
        end
        chk("t4.alarm_ended", int'(bus_a.alarm), 0);
        tick();
        chk("t4.unlock_after_alarm", int'(bus_a.locked), 0);
        chk("t4.credit5", int'(bus_a.credit), 5);

        // Reset during UNLOCKED with credit 5.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_unlocked");

        // Coin and push together with credit 2: unlock, no alarm.
        drive_a(1, 0);
        drive_a(1, 0);
        drive_a(1, 1);
        chk("t5.unlocked", int'(bus_a.locked), 0);
        chk("t5.credit1", int'(bus_a.credit), 1);
        chk("t5.no_alarm", int'(bus_a.alarm), 0);
        chk("t5.no_reject", int'(bus_a.coin_reject), 0);
        drive_a(0, 1);
        chk("t5.passed", int'(bus_a.passed), 1);

        // Reset during ALARM.
        drive_a(0, 1);
        chk("t6.in_alarm", int'(bus_a.alarm), 1);
        drive_a(0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_alarm");

        // Instance B: eight consecutive coins reach FARE=MAX_CREDIT=8.
        bus_b.coin = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bus_b.coin = 1'b0;
        chk("t7.credit8", int'(bus_b.credit), 8);
        chk("t7.locked", int'(bus_b.locked), 1);
        tick();
        chk("t7.unlocked", int'(bus_b.locked), 0);
        chk("t7.credit0", int'(bus_b.credit), 0);

        // Random traffic on both instances.
        for (int i = 0; i < 3000; i++) begin
            bus_a.coin = ($urandom_range(0, 99) < 40);
            bus_a.push = ($urandom_range(0, 99) < 15);
            bus_b.coin = ($urandom_range(0, 99) < 60);
            bus_b.push = ($urandom_range(0, 99) < 20);
            rst        = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        bus_a.coin = 1'b0; bus_a.push = 1'b0;
        bus_b.coin = 1'b0; bus_b.push = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
